// File: rtl/integer_execute.sv
// Integer ALU execute stage: accepts one issued op per cycle, holds the result in a
// one-entry output register, and broadcasts a wakeup on each completed writeback handshake.
module integer_execute #(
  parameter int XLEN             = 32,
  parameter int ROB_TAG_WIDTH    = 5,
  parameter int ALU_OP_WIDTH     = 4,
  parameter int ISSUE_DATA_WIDTH = ALU_OP_WIDTH + 2*XLEN + ROB_TAG_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_aL,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [ISSUE_DATA_WIDTH-1:0] issue_data,
  input  logic                        flush,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [ROB_TAG_WIDTH-1:0]    wb_rob_tag,
  output logic [XLEN-1:0]             wb_data,
  output logic                        wakeup_valid,
  output logic [ROB_TAG_WIDTH-1:0]    wakeup_tag,
  output logic [XLEN-1:0]             wakeup_data
);

  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD   = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB   = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLL   = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLT   = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU  = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR   = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRL   = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRA   = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR    = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND   = ALU_OP_WIDTH'(9);
  localparam logic [ALU_OP_WIDTH-1:0] OP_PASSB = ALU_OP_WIDTH'(10);

  logic [ALU_OP_WIDTH-1:0]  alu_op;
  logic [XLEN-1:0]          opa;
  logic [XLEN-1:0]          opb;
  logic [ROB_TAG_WIDTH-1:0] in_tag;
  logic [SHAMT_W-1:0]       shamt;
  logic [XLEN-1:0]          alu_result;

  logic                     out_valid;
  logic [ROB_TAG_WIDTH-1:0] out_tag;
  logic [XLEN-1:0]          out_data;
  logic                     accept;
  logic                     retire;

  assign {alu_op, opa, opb, in_tag} = issue_data;
  assign shamt = opb[SHAMT_W-1:0];

  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:   alu_result = opa + opb;
      OP_SUB:   alu_result = opa - opb;
      OP_SLL:   alu_result = opa << shamt;
      OP_SLT:   alu_result = XLEN'($signed(opa) < $signed(opb));
      OP_SLTU:  alu_result = XLEN'(opa < opb);
      OP_XOR:   alu_result = opa ^ opb;
      OP_SRL:   alu_result = opa >> shamt;
      OP_SRA:   alu_result = XLEN'($signed(opa) >>> shamt);
      OP_OR:    alu_result = opa | opb;
      OP_AND:   alu_result = opa & opb;
      OP_PASSB: alu_result = opb;
      default:  alu_result = '0;
    endcase
  end

  // A retiring result frees the register in the same cycle, so a new op can refill it.
  assign issue_ready = ~out_valid | wb_ready;
  assign accept      = issue_valid & issue_ready & ~flush;
  assign retire      = out_valid & wb_ready;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_tag   <= in_tag;
      out_data  <= alu_result;
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end

  assign wb_valid     = out_valid;
  assign wb_rob_tag   = out_tag;
  assign wb_data      = out_data;
  assign wakeup_valid = retire & ~flush;
  assign wakeup_tag   = out_tag;
  assign wakeup_data  = out_data;

endmodule

// File: tb/tb_integer_execute.sv
// Bench for integer_execute: queue-based scoreboard checked every cycle plus directed literal cases.
module tb_integer_execute;

  logic        clk;
  logic        rst_aL;
  logic        issue_valid;
  logic        issue_ready;
  logic [72:0] issue_data;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rob_tag;
  logic [31:0] wb_data;
  logic        wakeup_valid;
  logic [4:0]  wakeup_tag;
  logic [31:0] wakeup_data;

  integer_execute dut (
    .clk          (clk),
    .rst_aL       (rst_aL),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_data   (issue_data),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rob_tag   (wb_rob_tag),
    .wb_data      (wb_data),
    .wakeup_valid (wakeup_valid),
    .wakeup_tag   (wakeup_tag),
    .wakeup_data  (wakeup_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << sh;
      3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> sh;
      7:  return $signed(a) >>> sh;
      8:  return a | b;
      9:  return a & b;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct { logic [4:0] tag; logic [31:0] data; } result_t;
  result_t pending[$];
  int n_acc = 0;
  int exp_wake = 0;
  int act_wake = 0;

  // Model: results awaiting writeback in issue order; the stage can hold at most one.
  always @(negedge rst_aL) pending.delete();

  always @(posedge clk) begin
    if (rst_aL) begin
      bit may_take, retiring, taking;
      result_t r;
      retiring = (pending.size() != 0) && wb_ready;
      may_take = (pending.size() == 0) || wb_ready;
      taking   = issue_valid && may_take && !flush;
      if (wakeup_valid) act_wake++;
      if (flush) pending.delete();
      else begin
        if (retiring) begin
          void'(pending.pop_front());
          exp_wake++;
        end
        if (taking) begin
          r.tag  = issue_data[4:0];
          r.data = ref_alu(int'(issue_data[72:69]), issue_data[68:37], issue_data[36:5]);
          pending.push_back(r);
          n_acc++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_aL) begin
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    end else begin
      bit have;
      have = pending.size() != 0;
      chk("wb_valid", 32'(wb_valid), 32'(have));
      chk("issue_ready", 32'(issue_ready), 32'(!have || wb_ready));
      chk("wakeup_valid", 32'(wakeup_valid), 32'(have && wb_ready && !flush));
      if (have) begin
        chk("wb_data", wb_data, pending[0].data);
        chk("wb_rob_tag", 32'(wb_rob_tag), 32'(pending[0].tag));
        if (wakeup_valid) begin
          chk("wakeup_data", wakeup_data, pending[0].data);
          chk("wakeup_tag", 32'(wakeup_tag), 32'(pending[0].tag));
        end
      end
    end
  end

  function automatic logic [72:0] pack(input int op, input logic [31:0] a, input logic [31:0] b,
                                       input int tag);
    return {4'(op), a, b, 5'(tag)};
  endfunction

  // Issue a single op with wb_ready high and check the result one cycle later.
  task automatic issue_one(input string name, input int op, input logic [31:0] a,
                           input logic [31:0] b, input int tag, input logic [31:0] exp);
    issue_data  = pack(op, a, b, tag);
    issue_valid = 1'b1;
    wb_ready    = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    issue_data  = {73{1'b1}};
    @(negedge clk);
    chk({name, "_valid"}, 32'(wb_valid), 32'd1);
    chk({name, "_data"}, wb_data, exp);
    chk({name, "_tag"}, 32'(wb_rob_tag), 32'(tag));
    chk({name, "_wakeup"}, 32'(wakeup_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int base_acc, base_wk, cyc;
    rst_aL      = 1'b0;
    issue_valid = 1'b0;
    issue_data  = '0;
    flush       = 1'b0;
    wb_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_issue_ready", 32'(issue_ready), 32'd1);
    #2 rst_aL = 1'b1;
    @(posedge clk); #1;

    issue_one("add_wrap", 0, 32'hFFFF_FFFF, 32'd1, 7, 32'h0000_0000);
    issue_one("sra", 7, 32'h8000_0000, 32'h0000_0024, 1, 32'hF800_0000);
    issue_one("slt", 3, 32'hFFFF_FFFF, 32'd1, 2, 32'd1);
    issue_one("sltu", 4, 32'hFFFF_FFFF, 32'd1, 3, 32'd0);
    issue_one("sll", 2, 32'd1, 32'h0000_0021, 4, 32'd2);
    issue_one("srl", 6, 32'h8000_0000, 32'hFFFF_FFE4, 5, 32'h0800_0000);
    issue_one("passb", 10, 32'h1234_5678, 32'hABCD_0000, 6, 32'hABCD_0000);
    issue_one("rsvd", 12, 32'h1234_5678, 32'h1111_1111, 8, 32'd0);

    // Backpressure: A held for three cycles while B waits, then back-to-back refill.
    wb_ready    = 1'b0;
    issue_valid = 1'b1;
    issue_data  = pack(5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3);
    @(posedge clk); #1;
    issue_data  = pack(1, 32'd5, 32'd7, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_issue_ready", 32'(issue_ready), 32'd0);
      chk("stall_wb_data", wb_data, 32'hFF00_FF00);
      chk("stall_wakeup", 32'(wakeup_valid), 32'd0);
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    @(negedge clk);
    chk("drain_wakeup", 32'(wakeup_valid), 32'd1);
    chk("drain_issue_ready", 32'(issue_ready), 32'd1);
    @(posedge clk); #1;

    // Flush while B is valid and a new op is offered.
    flush      = 1'b1;
    issue_data = pack(8, 32'h1, 32'h2, 5);
    @(negedge clk);
    chk("b2b_wb_data", wb_data, 32'hFFFF_FFFE);
    chk("b2b_tag", 32'(wb_rob_tag), 32'd4);
    chk("flush_wakeup", 32'(wakeup_valid), 32'd0);
    @(posedge clk); #1;
    flush       = 1'b0;
    issue_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_valid", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;

    // Async reset while stalled: held result vanishes with no wakeup.
    wb_ready    = 1'b0;
    issue_valid = 1'b1;
    issue_data  = pack(9, 32'hFF00_FF00, 32'h0F0F_0F0F, 9);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(wb_valid), 32'd1);
    chk("pre_rst_data", wb_data, 32'h0F00_0F00);
    @(posedge clk); #2;
    wb_ready = 1'b1;
    rst_aL   = 1'b0;
    #1;
    chk("async_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("async_rst_wakeup", 32'(wakeup_valid), 32'd0);
    chk("async_rst_issue_ready", 32'(issue_ready), 32'd1);
    @(posedge clk); #3;
    rst_aL = 1'b1;
    @(posedge clk); #1;

    // Random stream: 20 accepted ops under random backpressure.
    base_acc = n_acc;
    base_wk  = act_wake;
    cyc      = 0;
    while ((n_acc - base_acc) < 20 && cyc < 500) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_data  = {4'($urandom_range(0, 15)), $urandom(), $urandom(), 5'(cyc)};
      wb_ready    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    issue_valid = 1'b0;
    wb_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stream_accepted", 32'(n_acc - base_acc), 32'd20);
    chk("stream_wakeups", 32'(act_wake - base_wk), 32'd20);
    chk("total_wakeups", 32'(act_wake), 32'(exp_wake));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
